// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the async_fifo write-side stream producer.
// Contents:
//   fsw_state_t     - burst controller state
//   FSW_SKID_DEPTH  - number of entries in the write skid buffer
//   fsw_is_active   - true while a burst is moving data (RUN or FLUSH)
package fifo_stream_pkg;

  localparam int unsigned FSW_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } fsw_state_t;

  function automatic logic fsw_is_active(input fsw_state_t st);
    return (st == StRun) || (st == StFlush);
  endfunction

endpackage

// File: rtl/fifo_wr_skid.sv
// Two-entry in-order buffer between the upstream sample stream and the FIFO
// write port. Entry 0 is always the head, so the FIFO sees registered data.
// Ports:
//   wr_clk, wr_rst_n - write-domain clock, asynchronous active-high reset
//   push, push_data  - enqueue one word (ignored when full and not popping)
//   pop              - dequeue the head (ignored when empty)
//   occupancy        - number of valid entries, 0..2
//   head_data        - current head word (0 after reset)
module fifo_wr_skid
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occupancy,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam logic [1:0] SkidFull = 2'(FSW_SKID_DEPTH);

  logic [DATA_WIDTH-1:0] entry_q [FSW_SKID_DEPTH];
  logic [DATA_WIDTH-1:0] entry_d [FSW_SKID_DEPTH];
  logic [1:0]            occ_q, occ_d;
  logic                  pop_ok, push_ok;

  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign pop_ok  = pop && (occ_q != 2'd0);
  assign push_ok = push && ((occ_q < SkidFull) || pop_ok);

  always_comb begin
    entry_d = entry_q;
    occ_d   = occ_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        entry_d[occ_q[0]] = push_data;
        occ_d             = occ_q + 2'd1;
      end
      2'b01: begin
        entry_d[0] = entry_q[1];
        occ_d      = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          entry_d[0] = push_data;
        end else begin
          entry_d[0] = entry_q[1];
          entry_d[1] = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst_n) begin
    if (wr_rst_n) begin
      entry_q <= '{default: '0};
      occ_q   <= 2'd0;
    end else begin
      entry_q <= entry_d;
      occ_q   <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign head_data = entry_q[0];

endmodule

// File: rtl/fifo_stream_writer.sv
// Write-side producer for async_fifo. Accepts a valid/ready sample stream,
// buffers it in a two-entry skid stage and writes the FIFO only while it is
// not full. Each burst moves burst_len samples; in backpressure mode the
// source is stalled, in drop mode samples that find the buffer full are
// discarded and counted.
// Ports:
//   wr_clk, wr_rst_n        - clock, asynchronous active-high reset
//   start, burst_len,
//   drop_mode               - burst request; parameters latched on accepted start
//   s_data, s_valid, s_ready- upstream stream (s_ready registered)
//   fifo_wr_data,
//   fifo_wr_en, fifo_full   - FIFO write port (wr_en combinational on full)
//   busy, done              - burst status; done is a one-cycle pulse
//   words_written,
//   drop_count              - per-burst saturating statistics
module fifo_stream_writer
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  drop_mode,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_written,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam logic [1:0]           SkidFull = 2'(FSW_SKID_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

  fsw_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] ww_q, ww_d;
  logic [CNT_WIDTH-1:0] dc_q, dc_d;
  logic                 drop_q, drop_d;
  logic                 s_ready_q, s_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop, push, beat, discard;

  fifo_wr_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .push     (push),
    .push_data(s_data),
    .pop      (pop),
    .occupancy(occ),
    .head_data(head)
  );

  // Drain path has no register stage so fifo_full blocks the write immediately.
  assign pop = (occ != 2'd0) && !fifo_full;

  // s_ready is only ever set for RUN, so this also bounds beats to the burst.
  assign beat = (state_q == StRun) && s_valid && s_ready_q;

  // In drop mode the source never stalls; a full buffer with no drain loses the sample.
  assign discard = drop_q && beat && (occ == SkidFull) && !pop;
  assign push    = beat && !discard;

  assign occ_next = occ + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    drop_d  = drop_q;
    acc_d   = acc_q;
    ww_d    = (pop && (ww_q != '1)) ? ww_q + CntOne : ww_q;
    dc_d    = (discard && (dc_q != '1)) ? dc_q + CntOne : dc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = burst_len;
          drop_d  = drop_mode;
          acc_d   = '0;
          ww_d    = '0;
          dc_d    = '0;
          state_d = (burst_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + CNT_WIDTH'(beat);
        if (acc_d == len_q) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (occ == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    // Look-ahead on next occupancy keeps the buffer from ever being over-offered
    // in backpressure mode.
    s_ready_d = (state_d == StRun) && (drop_d || (occ_next < SkidFull)) && (acc_d < len_d);
    busy_d    = fsw_is_active(state_d);
    done_d    = (state_q == StDone);
  end

  always_ff @(posedge wr_clk or posedge wr_rst_n) begin
    if (wr_rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      drop_q    <= 1'b0;
      acc_q     <= '0;
      ww_q      <= '0;
      dc_q      <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      drop_q    <= drop_d;
      acc_q     <= acc_d;
      ww_q      <= ww_d;
      dc_q      <= dc_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign fifo_wr_data  = head;
  assign fifo_wr_en    = pop;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = ww_q;
  assign drop_count    = dc_q;

endmodule
